// File: rtl/branch_resolve_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_queue_pkg
// Description : Shared structs for the branch resolve path. Holds the
//               predictor/flush-controller update record and the entry
//               stored by branch_resolve_queue.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_queue_pkg;

    // Field widths of the shared structs. Any block using these structs must
    // be instantiated with matching PC / ROB / branch-slot parameters.
    localparam int PKG_PC_BITS        = 32;
    localparam int PKG_ROB_INDEX_BITS = 3;
    localparam int PKG_MAX_BRANCH_IF  = 2;
    localparam int PKG_RAT_ID_BITS    = $clog2(PKG_MAX_BRANCH_IF);

    // Update sent to the branch predictor and the flush controller.
    typedef struct packed {
        logic                          valid_jump;
        logic                          jump_taken;
        logic [PKG_PC_BITS-1:0]        jump_address;
        logic [PKG_PC_BITS-1:0]        orig_pc;
        logic                          is_comp;
        logic [PKG_ROB_INDEX_BITS-1:0] ticket;
        logic [PKG_RAT_ID_BITS-1:0]    rat_id;
    } predictor_update;

    // One resolved branch waiting in the resolve queue.
    typedef struct packed {
        logic [PKG_PC_BITS-1:0]        orig_pc;
        logic [PKG_PC_BITS-1:0]        target;
        logic                          taken;
        logic                          is_comp;
        logic [PKG_ROB_INDEX_BITS-1:0] ticket;
        logic [PKG_RAT_ID_BITS-1:0]    rat_id;
    } branch_resolve_entry;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_queue
// Description : Program-order FIFO between the branch execution unit and the
//               predictor / flush controller. One cycle minimum latency, no
//               bypass. Flush empties the queue (pointers and counter only).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               flush             - misprediction flush
//               br_valid/br_ready - resolved-branch handshake, br_* payload
//               upd_ready         - downstream can take an update this cycle
//               pr_update         - head entry as a predictor update
//               occupancy         - number of valid entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int PC_BITS        = PKG_PC_BITS,
    parameter int ROB_INDEX_BITS = PKG_ROB_INDEX_BITS,
    parameter int MAX_BRANCH_IF  = PKG_MAX_BRANCH_IF,
    parameter int DEPTH          = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             br_valid,
    output logic                             br_ready,
    input  logic [PC_BITS-1:0]               br_orig_pc,
    input  logic [PC_BITS-1:0]               br_target,
    input  logic                             br_taken,
    input  logic                             br_is_comp,
    input  logic [ROB_INDEX_BITS-1:0]        br_ticket,
    input  logic [$clog2(MAX_BRANCH_IF)-1:0] br_rat_id,
    input  logic                             upd_ready,
    output predictor_update                  pr_update,
    output logic [$clog2(DEPTH):0]           occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] c_OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] c_OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

    // Storage carries no reset; only the pointers and counter define validity.
    branch_resolve_entry mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q,  occ_d;

    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    branch_resolve_entry w_new_entry;
    branch_resolve_entry w_head_entry;

    assign w_empty  = (occ_q == '0);
    assign br_ready = (occ_q != c_OCC_FULL);
    // Under flush a push is swallowed even though br_ready may be high.
    assign w_push   = br_valid && br_ready && !flush;
    // The presented head is consumed whenever downstream takes it, flush or not.
    assign w_pop    = !w_empty && upd_ready;

    assign occupancy    = occ_q;
    assign w_head_entry = mem_q[head_q];

    always_comb begin
        w_new_entry         = '0;
        w_new_entry.orig_pc = br_orig_pc;
        w_new_entry.target  = br_target;
        w_new_entry.taken   = br_taken;
        w_new_entry.is_comp = br_is_comp;
        w_new_entry.ticket  = br_ticket;
        w_new_entry.rat_id  = br_rat_id;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (w_push) begin
                tail_d = tail_q + c_PTR_ONE;
            end
            if (w_pop) begin
                head_d = head_q + c_PTR_ONE;
            end
            // Simultaneous push and pop leave the count unchanged.
            if (w_push && !w_pop) begin
                occ_d = occ_q + c_OCC_ONE;
            end else if (w_pop && !w_push) begin
                occ_d = occ_q - c_OCC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[tail_q] <= w_new_entry;
        end
    end

    always_comb begin
        pr_update = '0;
        if (!w_empty) begin
            pr_update.jump_address = w_head_entry.target;
            pr_update.jump_taken   = w_head_entry.taken;
            pr_update.orig_pc      = w_head_entry.orig_pc;
            pr_update.is_comp      = w_head_entry.is_comp;
            pr_update.ticket       = w_head_entry.ticket;
            pr_update.rat_id       = w_head_entry.rat_id;
        end
        pr_update.valid_jump = w_pop;
    end

endmodule
`default_nettype wire
